// File: rtl/shiftrows_pipe.sv
// shiftrows_pipe: pipelined Rijndael ShiftRows / InvShiftRows with valid/ready.
//   NB      state columns (4, 6 or 8); data width W = 32*NB
//   STAGES  register stages (1..4); latency from accept to o_valid
// Ports:
//   i_clk, i_rst (sync, active-high), i_flush (sync, active-high)
//   i_valid/o_ready/i_inv/i_din : input beat, mode tag sampled with it
//   o_valid/i_ready/o_dout/o_inv: output beat and its mode tag
//   o_busy                      : any stage holds a valid beat
// Byte k = 4*c + r (state s[r][c]) lives at bits [W-1-8k -: 8]; byte 0 is the MSB.

// One state row as a byte vector (column 0 in the MSBs), rotated by OFF.
//   row_in/row_out : NB bytes of one row
//   inv            : 0 = out[c] = in[(c+OFF)%NB], 1 = out[c] = in[(c-OFF)%NB]
module shiftrows_row #(
  parameter int NB  = 4,
  parameter int OFF = 0
) (
  input  logic [8*NB-1:0] row_in,
  input  logic            inv,
  output logic [8*NB-1:0] row_out
);
  for (genvar c = 0; c < NB; c++) begin : g_byte
    localparam int FWD = (c + OFF) % NB;
    localparam int BWD = (c + NB - OFF) % NB;
    assign row_out[8*NB-1-8*c -: 8] = inv ? row_in[8*NB-1-8*BWD -: 8]
                                          : row_in[8*NB-1-8*FWD -: 8];
  end
endmodule

module shiftrows_pipe #(
  parameter  int NB     = 4,
  parameter  int STAGES = 1,
  localparam int W      = 32*NB
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_inv,
  input  logic [W-1:0] i_din,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_dout,
  output logic         o_inv,
  output logic         o_busy
);
  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shiftrows_pipe: NB must be 4, 6 or 8");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("shiftrows_pipe: STAGES must be 1..4");
  end

  typedef struct packed {
    logic         inv;
    logic [W-1:0] dat;
  } beat_t;

  // ---- permutation (combinational, ahead of stage 1) ----
  logic [3:0][8*NB-1:0] rows_in, rows_out;
  logic [W-1:0]         perm;

  // Column-major state -> one byte vector per row, and back.
  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_cell
      assign rows_in[r][8*NB-1-8*c -: 8] = i_din[W-1-8*(4*c+r) -: 8];
      assign perm[W-1-8*(4*c+r) -: 8]    = rows_out[r][8*NB-1-8*c -: 8];
    end
  end

  // Row offsets: 0/1/2/3, except the 256-bit block which uses 0/1/3/4.
  for (genvar r = 0; r < 4; r++) begin : g_row
    localparam int OFF = (r == 0) ? 0 :
                         (r == 1) ? 1 :
                         (r == 2) ? ((NB == 8) ? 3 : 2) :
                                    ((NB == 8) ? 4 : 3);
    shiftrows_row #(.NB(NB), .OFF(OFF)) u_row (
      .row_in  (rows_in[r]),
      .inv     (i_inv),
      .row_out (rows_out[r])
    );
  end

  // ---- register slices ----
  beat_t [STAGES:1]   pipe_q, pipe_in;
  logic  [STAGES:1]   vld_pipe, vld_in;
  logic  [STAGES+1:1] rdy;   // rdy[s]: stage s may load; rdy[STAGES+1] = downstream

  always_comb begin
    vld_in     = '0;
    pipe_in    = '0;
    vld_in[1]  = i_valid;
    pipe_in[1] = {i_inv, perm};
    for (int s = 2; s <= STAGES; s++) begin
      vld_in[s]  = vld_pipe[s-1];
      pipe_in[s] = pipe_q[s-1];
    end
  end

  // A stage can load when empty or when its own contents are moving on,
  // so the ready chain ripples back combinationally and never leaves a bubble.
  always_comb begin
    rdy           = '0;
    rdy[STAGES+1] = i_ready;
    for (int s = STAGES; s >= 1; s--) rdy[s] = !vld_pipe[s] || rdy[s+1];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_pipe <= '0;
      pipe_q   <= '0;
    end else if (i_flush) begin
      vld_pipe <= '0;   // data left in place; only the valid bits matter
    end else begin
      for (int s = 1; s <= STAGES; s++) begin
        if (rdy[s]) begin
          vld_pipe[s] <= vld_in[s];
          // Hold data when no beat arrives so it is never disturbed needlessly.
          if (vld_in[s]) pipe_q[s] <= pipe_in[s];
        end
      end
    end
  end

  assign o_ready = !i_rst && !i_flush && rdy[1];
  assign o_valid = vld_pipe[STAGES];
  assign o_dout  = pipe_q[STAGES].dat;
  assign o_inv   = pipe_q[STAGES].inv;
  assign o_busy  = |vld_pipe;
endmodule
